// File: rtl/xcfi_check_sequencer.sv
// Picks the XCFI check cycle: strobes `check` on the first eligible retirement inside
// [CHECK_MIN, CHECK_MAX], and tracks order continuity, timeout and early halt.
module xcfi_check_sequencer #(
    parameter int unsigned CHECK_MIN = 10,
    parameter int unsigned CHECK_MAX = 30,
    parameter int unsigned ORDER_MIN = 0,
    parameter int unsigned CWIDTH    = 8,
    parameter int unsigned OWIDTH    = 64
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              rvfi_valid,
    input  logic [OWIDTH-1:0] rvfi_order,
    input  logic              rvfi_halt,
    output logic              check,
    output logic [OWIDTH-1:0] check_order,
    output logic [CWIDTH-1:0] cycle_count,
    output logic [1:0]        state,
    output logic              busy,
    output logic              order_err,
    output logic              timeout,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [CWIDTH-1:0] LP_ARM_AT    = CWIDTH'(CHECK_MIN - 1);
    localparam logic [CWIDTH-1:0] LP_MAX_AT    = CWIDTH'(CHECK_MAX);
    localparam logic [CWIDTH-1:0] LP_SAT       = {CWIDTH{1'b1}};
    localparam logic [OWIDTH-1:0] LP_ORDER_MIN = OWIDTH'(ORDER_MIN);
    localparam state_t            LP_RST_STATE = (CHECK_MIN == 0) ? ST_ARMED : ST_WAIT;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CWIDTH-1:0] r_cycle_count;
    logic [OWIDTH-1:0] r_check_order;
    logic [OWIDTH-1:0] r_expected;
    logic              r_first_seen;
    logic              r_order_err;
    logic              r_timeout;
    logic              r_halted;
    logic              w_set_timeout;
    logic              w_set_halted;
    logic              w_eligible;
    logic              w_check;
    logic              w_order_bad;
    logic [OWIDTH:0]   w_order_diff;

    // Borrow-out of the subtraction gives order >= ORDER_MIN without a constant compare when ORDER_MIN is 0.
    assign w_order_diff = {1'b0, rvfi_order} - {1'b0, LP_ORDER_MIN};
    assign w_eligible   = rvfi_valid && !w_order_diff[OWIDTH];
    assign w_check      = g_resetn && (r_state == ST_ARMED) && w_eligible;
    assign w_order_bad  = rvfi_valid &&
                          (r_first_seen ? (rvfi_order != r_expected) : (rvfi_order != '0));

    always_comb begin
        w_state_nxt   = r_state;
        w_set_timeout = 1'b0;
        w_set_halted  = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (rvfi_valid && rvfi_halt) begin
                    w_state_nxt  = ST_ABORT;
                    w_set_halted = 1'b1;
                end else if (r_cycle_count == LP_ARM_AT) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_check) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    if (rvfi_valid && rvfi_halt) begin
                        w_state_nxt  = ST_ABORT;
                        w_set_halted = 1'b1;
                    end
                    if (r_cycle_count == LP_MAX_AT) begin
                        w_state_nxt   = ST_ABORT;
                        w_set_timeout = 1'b1;
                    end
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state       <= LP_RST_STATE;
            r_cycle_count <= '0;
            r_check_order <= '0;
            r_expected    <= '0;
            r_first_seen  <= 1'b0;
            r_order_err   <= 1'b0;
            r_timeout     <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_cycle_count != LP_SAT) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
            if (w_check) begin
                r_check_order <= rvfi_order;
            end
            if (rvfi_valid) begin
                r_expected   <= rvfi_order + 1'b1;
                r_first_seen <= 1'b1;
            end
            if (w_order_bad)   r_order_err <= 1'b1;
            if (w_set_timeout) r_timeout   <= 1'b1;
            if (w_set_halted)  r_halted    <= 1'b1;
        end
    end

    assign check       = w_check;
    assign check_order = r_check_order;
    assign cycle_count = r_cycle_count;
    assign state       = r_state;
    assign busy        = (r_state == ST_WAIT) || (r_state == ST_ARMED);
    assign order_err   = r_order_err;
    assign timeout     = r_timeout;
    assign halted      = r_halted;

endmodule

// File: doc/xcfi_check_sequencer.md
Name: xcfi_check_sequencer

Overview:
Sequences the formal check window for the XCFI flow. It watches the retirement trace and raises a single-cycle `check` strobe on the first eligible retirement inside a cycle window. It also tracks order continuity, timeout and early halt. It sits between the DUT wrapper's rvfi_* outputs and the instruction checker's `check` input, replacing a fixed check cycle.

Parameters:
CHECK_MIN, 10, first cycle after reset at which `check` may fire
CHECK_MAX, 30, last cycle at which `check` may fire; a legal value satisfies CHECK_MIN <= CHECK_MAX < 2^CWIDTH-1
ORDER_MIN, 0, minimum rvfi_order value eligible for checking
CWIDTH, 8, cycle counter width
OWIDTH, 64, rvfi_order width

Ports:
g_clk  input  1  clock
g_resetn  input  1  synchronous reset, active low
rvfi_valid  input  1  retirement valid (NRET=1)
rvfi_order  input  OWIDTH  retirement order number
rvfi_halt  input  1  retired instruction halts the hart
check  output  1  sample strobe to the instruction checker, same cycle as the checked rvfi_* values
check_order  output  OWIDTH  order of the checked instruction, registered
cycle_count  output  CWIDTH  cycles since reset release
state  output  2  0=WAIT, 1=ARMED, 2=DONE, 3=ABORT
busy  output  1  state is WAIT or ARMED
order_err  output  1  sticky: order discontinuity seen
timeout  output  1  sticky: window closed without a check
halted  output  1  sticky: halt retired before a check

Behaviour:
- Interface: one clock, g_clk. Reset g_resetn is synchronous and active-low.
- Reset (g_resetn=0 at posedge) gives: cycle_count=0, state=WAIT, check_order=0, order_err=0, timeout=0, halted=0, expected-order register cleared, first-seen flag cleared.
- `check` is forced to 0 while g_resetn=0. A mid-operation reset restarts everything.
- cycle_count increments by 1 on every cycle out of reset and saturates at 2^CWIDTH-1. It never wraps.
- eligible = rvfi_valid && rvfi_order >= ORDER_MIN.
- check is combinational: (state==ARMED) && eligible. It is high for at most one cycle per reset.
- State machine; every transition is evaluated on the registered state and the current inputs:
  - WAIT -> ARMED when cycle_count == CHECK_MIN-1, so ARMED is valid from cycle CHECK_MIN. If CHECK_MIN==0, reset enters ARMED directly.
  - WAIT -> ABORT on rvfi_valid && rvfi_halt; set halted. Retirements in WAIT never fire check.
  - ARMED -> DONE when check=1; check_order <= rvfi_order.
  - ARMED -> ABORT on rvfi_valid && rvfi_halt && !check; set halted.
  - ARMED -> ABORT when cycle_count == CHECK_MAX && !check; set timeout.
  - DONE and ABORT are absorbing until reset.
- Priority at the same edge: check beats timeout; check beats halt. An eligible halting instruction is checked and the state goes to DONE, with halted=0.
- Order monitor, active in all states:
  - The first rvfi_valid after reset must carry order 0.
  - Each later rvfi_valid must carry order == previous+1.
  - Any mismatch sets order_err, and it stays set until reset.
  - expected <= rvfi_order+1 on every valid, using OWIDTH-bit wrapping add.
- order_err does not change state and does not suppress check.
- busy = (state==WAIT)||(state==ARMED), decoded from registered state.
- Latency: check has 0 cycles from rvfi_valid. check_order and the state change are visible 1 cycle later.

Test Plan:
- CHECK_MIN=10, CHECK_MAX=30; retirements every cycle from cycle 3 with orders 0,1,2,... -> no check before cycle 10; check=1 only at cycle 10 with order 7; next cycle state=2, check_order=7, busy=0.
- No rvfi_valid at all -> state stays ARMED through cycle 30; state=3 and timeout=1 from cycle 31; check never asserts.
- Single eligible retirement exactly at cycle 30 -> check=1 at cycle 30; state=2; timeout stays 0.
- rvfi_valid with rvfi_halt at cycle 5 -> halted=1, state=3; a valid at cycle 12 produces no check. Separately, a halt retiring at cycle 15 in ARMED -> check=1, state=2, halted=0.
- Orders 0,1,3 on consecutive valids -> order_err=1 after the third valid and stays 1; check still fires normally in the window. A first valid with order 5 -> order_err=1.
- ORDER_MIN=4, orders 0.. starting cycle 8 -> check fires on order 4 at cycle 12, not at cycle 10. Drive g_resetn=0 for one cycle at cycle 11 -> all outputs return to reset values and the counter restarts from 0.
